// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB memory slave: FSM encoding, wait
// counter width, byte-offset and word-index arithmetic.
package apb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_state_e;

  localparam int WCNT_W = 4;

  // Number of byte-address bits below the word index.
  function automatic int calc_ofs(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Word index of a byte address.
  function automatic logic [31:0] word_idx(input logic [31:0] addr, input int ofs);
    return addr >> ofs;
  endfunction

endpackage

// File: rtl/apb_mem_if.sv
// APB4 bus bundle between a master (bridge/decoder or bench) and the memory
// slave. The pstrb lane-enable signal exists only when APB_MEM_STRB_EN is
// defined.
interface apb_mem_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
`ifdef APB_MEM_STRB_EN
  logic [DATA_W/8-1:0] pstrb;
`endif
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

`ifdef APB_MEM_STRB_EN
  modport master (output psel, penable, pwrite, paddr, pwdata, pstrb,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata, pstrb,
                  output prdata, pready, pslverr);
`else
  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
`endif

endinterface

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W storage: synchronous write with per-byte-lane enables and an
// asynchronous read port. Contents are deliberately not reset.
module apb_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic [DATA_W/8-1:0] we,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [IDX_W-1:0]    raddr,
  output logic [DATA_W-1:0]   rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write; lanes with a clear enable keep their old contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_mem_slave.sv
// APB4 scratch-RAM slave with a fixed number of access-phase wait states.
// Misaligned or out-of-range accesses complete with pslverr and never touch
// memory. Optional byte strobes are enabled by defining APB_MEM_STRB_EN.
//
// state | meaning
// IDLE  | waiting for a setup phase; decode and latch the access there
// WAIT  | counting down wait states while the master holds the access phase
// RESP  | pready high for one cycle; a clean write commits at its end
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input logic     pclk,
  input logic     preset,
  apb_mem_if.slave bus
);

  localparam int                OFS   = calc_ofs(DATA_W);
  localparam int                NB    = DATA_W / 8;
  localparam int                IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WCNT_W-1:0] WS    = WCNT_W'(WAIT_STATES);

  apb_state_e        state;
  logic [WCNT_W-1:0] wcnt;
  logic              wr_q;
  logic              err_q;
  logic [IDX_W-1:0]  idx_q;
  logic              pready_q;
  logic              pslverr_q;
  logic [DATA_W-1:0] prdata_q;

  logic              setup;
  logic [31:0]       addr32;
  logic [31:0]       idx_full;
  logic              misalign;
  logic              oob;
  logic              strb_err;
  logic              err_now;
  logic [IDX_W-1:0]  idx_now;
  logic [IDX_W-1:0]  raddr;
  logic [DATA_W-1:0] rdata;
  logic [NB-1:0]     lane_mask;
  logic              commit;
  logic [NB-1:0]     we;

  // Setup-phase address decode and lane selection.
  always_comb begin
    setup    = bus.psel && !bus.penable;
    addr32   = 32'(bus.paddr);
    idx_full = word_idx(addr32, OFS);
    misalign = (addr32 & ((32'd1 << OFS) - 32'd1)) != 32'd0;
    oob      = idx_full >= 32'(DEPTH);
    idx_now  = idx_full[IDX_W-1:0];
`ifdef APB_MEM_STRB_EN
    // A read carrying any strobe is an APB4 protocol error.
    strb_err  = !bus.pwrite && (bus.pstrb != '0);
    lane_mask = bus.pstrb;
`else
    strb_err  = 1'b0;
    lane_mask = '1;
`endif
    err_now  = misalign || oob || strb_err;
    // In IDLE the response (zero wait states) reads the address being decoded.
    raddr    = (state == IDLE) ? idx_now : idx_q;
    // Reset on the same edge drops a pending write.
    commit   = (state == RESP) && bus.psel && bus.penable && wr_q && !err_q && !preset;
    we       = commit ? lane_mask : '0;
  end

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (pclk),
    .we    (we),
    .waddr (idx_q),
    .wdata (bus.pwdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Transfer FSM with wait counter and registered response outputs.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      wcnt      <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      case (state)
        IDLE: begin
          if (setup) begin
            wr_q  <= bus.pwrite;
            err_q <= err_now;
            idx_q <= idx_now;
            wcnt  <= WS;
            if (WAIT_STATES == 0) begin
              state     <= RESP;
              pready_q  <= 1'b1;
              pslverr_q <= err_now;
              prdata_q  <= (!bus.pwrite && !err_now) ? rdata : '0;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // Losing psel mid-transfer abandons it before any response.
          if (!bus.psel) begin
            state <= IDLE;
          end else if (bus.penable) begin
            wcnt <= wcnt - 1'b1;
            if (wcnt == WCNT_W'(1)) begin
              state     <= RESP;
              pready_q  <= 1'b1;
              pslverr_q <= err_q;
              prdata_q  <= (!wr_q && !err_q) ? rdata : '0;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = prdata_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: one instance with two wait states, one with none.
// Expected results come from a word-array model and the address rules.
module tb_apb_mem_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  apb_mem_if #(.ADDR_W(12), .DATA_W(32)) ia ();
  apb_mem_if #(.ADDR_W(12), .DATA_W(32)) ib ();

  apb_mem_slave #(.ADDR_W(12), .DATA_W(32), .DEPTH(16), .WAIT_STATES(2)) dut_a (
    .pclk(clk), .preset(rst), .bus(ia));
  apb_mem_slave #(.ADDR_W(12), .DATA_W(32), .DEPTH(16), .WAIT_STATES(0)) dut_b (
    .pclk(clk), .preset(rst), .bus(ib));

  logic [31:0] model_a [16];
  logic [31:0] model_b [4];

  function automatic bit exp_err(input logic [11:0] a, input bit wr, input logic [3:0] s);
    bit e;
    e = (a % 4 != 0) || (a / 4 >= 16);
`ifdef APB_MEM_STRB_EN
    if (!wr && s != 4'h0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  task automatic drive(input bit which, input logic sel, input logic en, input logic wr,
                       input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    if (which) begin
      ib.psel = sel; ib.penable = en; ib.pwrite = wr; ib.paddr = a; ib.pwdata = d;
`ifdef APB_MEM_STRB_EN
      ib.pstrb = s;
`endif
    end else begin
      ia.psel = sel; ia.penable = en; ia.pwrite = wr; ia.paddr = a; ia.pwdata = d;
`ifdef APB_MEM_STRB_EN
      ia.pstrb = s;
`endif
    end
  endtask

  // One APB transfer; cyc counts access cycles up to pready (-1 on timeout).
  task automatic xfer(input bit which, input bit wr, input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit b2b,
                      output logic [31:0] rd, output logic err, output int cyc);
    logic rdy;
    @(posedge clk); #1;
    drive(which, 1'b1, 1'b0, wr, a, d, s);
    @(posedge clk); #1;
    drive(which, 1'b1, 1'b1, wr, a, d, s);
    cyc = 1;
    rdy = which ? ib.pready : ia.pready;
    while (!rdy && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      rdy = which ? ib.pready : ia.pready;
    end
    if (!rdy) cyc = -1;
    rd  = which ? ib.prdata : ia.prdata;
    err = which ? ib.pslverr : ia.pslverr;
    if (!b2b) begin
      @(posedge clk); #1;
      drive(which, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ia.pready !== 1'b0) begin failures++; $display("FAIL reset_pready_a got=%b exp=0", ia.pready); end
    checks++; if (ia.pslverr !== 1'b0) begin failures++; $display("FAIL reset_pslverr_a got=%b exp=0", ia.pslverr); end
    checks++; if (ia.prdata !== 32'h0) begin failures++; $display("FAIL reset_prdata_a got=%h exp=0", ia.prdata); end
    checks++; if (ib.pready !== 1'b0) begin failures++; $display("FAIL reset_pready_b got=%b exp=0", ib.pready); end
    checks++; if (ib.prdata !== 32'h0) begin failures++; $display("FAIL reset_prdata_b got=%h exp=0", ib.prdata); end
    rst = 1'b0;
  endtask

  task automatic test_preload();
    logic [31:0] rd, d;
    logic err;
    int cyc;
    for (int i = 0; i < 16; i++) begin
      d = (i == 3) ? 32'h0 : $urandom;
      xfer(1'b0, 1'b1, 12'(i * 4), d, 4'hF, 1'b0, rd, err, cyc);
      model_a[i] = d;
      checks++; if (cyc !== 3) begin failures++; $display("FAIL preload_latency idx=%0d got=%0d exp=3", i, cyc); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL preload_err idx=%0d got=%b exp=0", i, err); end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    logic err;
    int cyc;
    xfer(1'b0, 1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 1'b0, rd, err, cyc);
    model_a[1] = 32'hDEADBEEF;
    checks++; if (cyc !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", cyc); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", err); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL wr_prdata got=%h exp=0", rd); end
    xfer(1'b0, 1'b0, 12'h004, 32'h0, 4'h0, 1'b0, rd, err, cyc);
    checks++; if (cyc !== 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", cyc); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", err); end
    checks++; if (ia.pready !== 1'b0) begin failures++; $display("FAIL pready_clear got=%b exp=0", ia.pready); end
    checks++; if (ia.prdata !== 32'h0) begin failures++; $display("FAIL prdata_clear got=%h exp=0", ia.prdata); end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic err;
    int cyc;
    xfer(1'b0, 1'b0, 12'h040, 32'h0, 4'h0, 1'b0, rd, err, cyc);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL oob_rd_err got=%b exp=1", err); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL oob_rd_data got=%h exp=0", rd); end
    checks++; if (cyc !== 3) begin failures++; $display("FAIL oob_rd_latency got=%0d exp=3", cyc); end
    xfer(1'b0, 1'b1, 12'h040, $urandom, 4'hF, 1'b0, rd, err, cyc);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL oob_wr_err got=%b exp=1", err); end
    for (int i = 0; i < 16; i++) begin
      xfer(1'b0, 1'b0, 12'(i * 4), 32'h0, 4'h0, 1'b0, rd, err, cyc);
      checks++; if (rd !== model_a[i]) begin failures++; $display("FAIL oob_wr_unchanged idx=%0d got=%h exp=%h", i, rd, model_a[i]); end
    end
    xfer(1'b0, 1'b1, 12'h002, 32'h12345678, 4'hF, 1'b0, rd, err, cyc);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL misalign_err got=%b exp=1", err); end
    xfer(1'b0, 1'b0, 12'h000, 32'h0, 4'h0, 1'b0, rd, err, cyc);
    checks++; if (rd !== model_a[0]) begin failures++; $display("FAIL misalign_no_write got=%h exp=%h", rd, model_a[0]); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL misalign_followup_err got=%b exp=0", err); end
  endtask

  task automatic test_random();
    logic [31:0] rd, d, exp_rd;
    logic [11:0] a;
    logic [3:0]  s;
    logic err;
    bit   wr, e;
    int   cyc, w;
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom_range(0, 1));
      w  = $urandom_range(0, 19);
      a  = 12'(w * 4 + (($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0));
      d  = $urandom;
      s  = 4'hF;
`ifdef APB_MEM_STRB_EN
      if (wr) s = 4'($urandom_range(0, 15));
      else    s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
`endif
      e = exp_err(a, wr, s);
      exp_rd = (wr || e) ? 32'h0 : model_a[a / 4];
      xfer(1'b0, wr, a, d, s, 1'b0, rd, err, cyc);
      if (wr && !e) model_a[a / 4] = merge(model_a[a / 4], d, s);
      checks++; if (err !== e) begin failures++; $display("FAIL rand_err n=%0d addr=%h wr=%b got=%b exp=%b", n, a, wr, err, e); end
      checks++; if (rd !== exp_rd) begin failures++; $display("FAIL rand_data n=%0d addr=%h wr=%b got=%h exp=%h", n, a, wr, rd, exp_rd); end
      checks++; if (cyc !== 3) begin failures++; $display("FAIL rand_latency n=%0d got=%0d exp=3", n, cyc); end
    end
  endtask

`ifdef APB_MEM_STRB_EN
  task automatic test_strobe();
    logic [31:0] rd;
    logic err;
    int cyc;
    xfer(1'b0, 1'b1, 12'h008, 32'h11223344, 4'hF, 1'b0, rd, err, cyc);
    xfer(1'b0, 1'b1, 12'h008, 32'hAABBCCDD, 4'b0010, 1'b0, rd, err, cyc);
    model_a[2] = 32'h1122CC44;
    xfer(1'b0, 1'b0, 12'h008, 32'h0, 4'h0, 1'b0, rd, err, cyc);
    checks++; if (rd !== 32'h1122CC44) begin failures++; $display("FAIL strobe_merge got=%h exp=1122cc44", rd); end
    xfer(1'b0, 1'b0, 12'h008, 32'h0, 4'b0100, 1'b0, rd, err, cyc);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL strobe_read_err got=%b exp=1", err); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL strobe_read_data got=%h exp=0", rd); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic err;
    int cyc;
    xfer(1'b0, 1'b1, 12'h00C, 32'h0, 4'hF, 1'b0, rd, err, cyc);
    model_a[3] = 32'h0;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 12'h00C, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 12'h00C, 32'hCAFEF00D, 4'hF);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (ia.pready !== 1'b0) begin failures++; $display("FAIL midrst_pready got=%b exp=0", ia.pready); end
    checks++; if (ia.prdata !== 32'h0) begin failures++; $display("FAIL midrst_prdata got=%h exp=0", ia.prdata); end
    checks++; if (ia.pslverr !== 1'b0) begin failures++; $display("FAIL midrst_pslverr got=%b exp=0", ia.pslverr); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    rst = 1'b0;
    xfer(1'b0, 1'b0, 12'h00C, 32'h0, 4'h0, 1'b0, rd, err, cyc);
    checks++; if (rd !== model_a[3]) begin failures++; $display("FAIL midrst_dropped got=%h exp=%h", rd, model_a[3]); end
    checks++; if (cyc !== 3) begin failures++; $display("FAIL midrst_followup_latency got=%0d exp=3", cyc); end
  endtask

  task automatic test_abort();
    logic [31:0] rd, d;
    logic err;
    int cyc, seen;
    d = ~model_a[4];
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 12'h010, d, 4'hF);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 12'h010, d, 4'hF);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (ia.pready === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL abort_pready got=%0d cycles exp=0", seen); end
    xfer(1'b0, 1'b0, 12'h010, 32'h0, 4'h0, 1'b0, rd, err, cyc);
    checks++; if (rd !== model_a[4]) begin failures++; $display("FAIL abort_no_write got=%h exp=%h", rd, model_a[4]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic err;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      model_b[i] = $urandom;
      xfer(1'b1, 1'b1, 12'(i * 4), model_b[i], 4'hF, 1'b1, rd, err, cyc);
      checks++; if (cyc !== 1) begin failures++; $display("FAIL b2b_wr_latency i=%0d got=%0d exp=1", i, cyc); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL b2b_wr_err i=%0d got=%b exp=0", i, err); end
    end
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 1'b0, 12'(i * 4), 32'h0, 4'h0, (i != 3), rd, err, cyc);
      checks++; if (cyc !== 1) begin failures++; $display("FAIL b2b_rd_latency i=%0d got=%0d exp=1", i, cyc); end
      checks++; if (rd !== model_b[i]) begin failures++; $display("FAIL b2b_rd_data i=%0d got=%h exp=%h", i, rd, model_b[i]); end
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    test_reset();
    test_preload();
    test_write_read();
    test_errors();
    test_random();
`ifdef APB_MEM_STRB_EN
    test_strobe();
`endif
    test_reset_mid();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB4 memory-mapped slave with configurable data width, depth and a fixed number of wait states. It decodes errors on out-of-range and misaligned accesses and optionally supports byte strobes. It sits behind the APB bridge/decoder as a register/scratch-RAM target and generalises the single 8-bit, 16-entry, zero-wait slave.

## Interface
- ADDR_W, 12: PADDR width; byte address.
- DATA_W, 32: data width; 8, 16 or 32.
- DEPTH, 256: number of DATA_W words; index ≥ DEPTH is an error.
- WAIT_STATES, 0: access-phase wait cycles, 0..15.
- PCLK  in  1  clock, rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  DATA_W  write data.
- PSTRB  in  DATA_W/8  byte lane enables; present only with APB_MEM_STRB_EN.
- PRDATA  out  DATA_W  read data; valid when PREADY=1 and PWRITE=0.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error; valid only when PREADY=1.

## Operation
- Constants: OFS = log2(DATA_W/8), idx = PADDR[ADDR_W-1:OFS].
- Error when any PADDR[OFS-1:0] ≠ 0 (misaligned) or idx ≥ DEPTH. Decode happens in the setup cycle.
- FSM states:
  - IDLE: on PSEL & !PENABLE (setup), latch PWRITE, idx and error. Load wcnt = WAIT_STATES.
    - If WAIT_STATES = 0, go to RESP.
    - Otherwise go to WAIT.
  - WAIT: decrement wcnt while PSEL & PENABLE. When wcnt reaches 1, go to RESP.
  - RESP: PREADY = 1 for exactly one cycle, then return to IDLE.
- PREADY, PRDATA and PSLVERR are registered. They are loaded on the edge that enters RESP and cleared on the edge that leaves it.
- Read data in RESP:
  - Normal read: PRDATA = mem[idx].
  - Error read, write, or any cycle outside RESP: PRDATA = 0.
- Write commit: mem[idx] is updated at the edge ending the RESP cycle, only if PSEL & PENABLE & PWRITE & !error.
- PSLVERR = latched error in RESP. Errored writes never modify memory.
- Abort: if PSEL drops in WAIT or RESP (protocol violation), go to IDLE next edge. PREADY/PSLVERR/PRDATA clear and no write occurs.
- Memory contents are not reset (X until written). Only control/state registers reset.

## Timing
- Reset values: PREADY = 0, PSLVERR = 0, PRDATA = 0, state = IDLE, wcnt = 0.
- Reset mid-transfer: next edge returns all outputs to reset values and any pending write is dropped.
- Setup at cycle T0, first access cycle T1, PREADY high at T1+WAIT_STATES.
  - WAIT_STATES = 0 gives the minimum 2-cycle transfer.
- Back-to-back: a setup phase in the cycle right after RESP is accepted with no idle gap.
- Write data is visible to a read whose setup starts in the cycle after the write's RESP.
- PADDR/PWRITE/PWDATA/PSTRB must be stable from setup to RESP. The design relies on latched idx/PWRITE and samples PWDATA/PSTRB in RESP.

## Configuration
- APB_MEM_STRB_EN defined:
  - The PSTRB port exists.
  - Only lanes with PSTRB[i] = 1 are written.
  - A read with PSTRB ≠ 0 returns PSLVERR = 1 (APB4 rule).
- Not defined:
  - No PSTRB port.
  - Every write updates all DATA_W/8 lanes.
  - Reads carry no strobe check.

## Structure
- Package apb_mem_pkg holds:
  - the FSM enum (IDLE, WAIT, RESP);
  - the WCNT_W localparam (4);
  - a function computing OFS from DATA_W;
  - the word-index function.
- Sub-module apb_mem_array: DEPTH × DATA_W storage with synchronous write, per-lane write enable and asynchronous read port. It has no reset.
- Top level: FSM, error decode, wait counter and output registers.

## Test plan
All scenarios use DATA_W = 32, DEPTH = 16, WAIT_STATES = 2 unless noted.
- Write 0xDEADBEEF @0x004, then read @0x004: PREADY at T1+2 each time, PRDATA = 0xDEADBEEF, PSLVERR = 0.
- Read @0x040 (idx 16): PSLVERR = 1, PRDATA = 0. Write @0x040: PSLVERR = 1 and all 16 words unchanged.
- Write 0x12345678 @0x002 (misaligned): PSLVERR = 1. A subsequent read @0x000 returns its prior value.
- APB_MEM_STRB_EN: write 0x11223344 @0x008, then write 0xAABBCCDD with PSTRB = 4'b0010. Read @0x008 returns 0x1122CC44.
- Reset asserted in the WAIT cycle of a write of 0xCAFEF00D @0x00C: next cycle PREADY = 0 and PRDATA = 0. A read after reset does not return 0xCAFEF00D (preload 0x0 before the test).
- WAIT_STATES = 0: four back-to-back writes then reads @0x000..0x00C complete in 2 cycles each with correct data. Dropping PSEL mid-WAIT (WAIT_STATES = 2) produces no PREADY and no write.
